// File: rtl/chaos_key_pkg.sv
// Shared register map, bit positions and FSM state type for the chaos key controller.
package chaos_key_pkg;

    // Register addresses
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_WARMUP  = 3'd2;
    localparam logic [2:0] ADDR_KEYLEN  = 3'd3;
    localparam logic [2:0] ADDR_KEYDATA = 3'd4;

    // CTRL bit positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_DONE      = 1;
    localparam int unsigned STAT_UNDERFLOW = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWarm,
        StCollect,
        StDone
    } state_e;

endpackage

// File: rtl/chaos_key_fifo.sv
// Synchronous first-word-fall-through FIFO holding the captured key words.
module chaos_key_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full buffer is only accepted when a pop frees a slot the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; flush discards everything
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // The controller bounds each session to DEPTH words, so overflow must never happen
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(i_push && !i_flush && o_full && !w_do_pop));

endmodule

// File: rtl/chaos_key_ctrl.sv
// Avalon-MM controller that warms up the chaos generator, captures a key and raises done/irq.
module chaos_key_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WARM_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              chaos_en,
    input  logic              chaos_valid,
    input  logic [DATA_W-1:0] chaos_data
);

    import chaos_key_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e             r_state;
    state_e             w_state_next;
    logic [WARM_W-1:0]  r_warm_cnt;
    logic [WARM_W-1:0]  w_warm_cnt_next;
    logic [CNT_W-1:0]   r_cap_cnt;
    logic [CNT_W-1:0]   w_cap_cnt_next;
    logic [CNT_W-1:0]   w_cap_inc;
    logic [CNT_W-1:0]   r_keylen_lat;
    logic [WARM_W-1:0]  r_warmup;
    logic [CNT_W-1:0]   r_keylen;
    logic               r_irq_en;
    logic               r_done;
    logic               r_underflow;
    logic               r_chaos_en;

    logic               w_wr;
    logic               w_rd;
    logic               w_start;
    logic               w_abort;
    logic               w_busy;
    logic               w_go;
    logic               w_push;
    logic               w_last;
    logic               w_pop_req;
    logic               w_pop;
    logic               w_underflow_set;
    logic               w_status_wr;
    logic [DATA_W-1:0]  w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;
    logic               w_unused;

    assign w_wr    = chipselect && !write_n;
    assign w_rd    = chipselect && !read_n;
    // Abort dominates a simultaneous start
    assign w_abort = w_wr && (address == ADDR_CTRL) && writedata[CTRL_ABORT];
    assign w_start = w_wr && (address == ADDR_CTRL) && writedata[CTRL_START] && !w_abort;
    assign w_busy  = (r_state == StWarm) || (r_state == StCollect);
    assign w_go    = w_start && !w_busy;
    assign w_status_wr = w_wr && (address == ADDR_STATUS);

    assign w_push    = (r_state == StCollect) && chaos_valid && !w_abort;
    assign w_cap_inc = r_cap_cnt + CNT_W'(1);
    assign w_last    = w_push && (w_cap_inc == r_keylen_lat);

    assign w_pop_req       = w_rd && (address == ADDR_KEYDATA);
    assign w_pop           = w_pop_req && !w_empty;
    assign w_underflow_set = w_pop_req && w_empty;

    assign irq      = r_done && r_irq_en;
    assign chaos_en = r_chaos_en;
    assign w_unused = ^{writedata, w_full};

    chaos_key_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_flush   (w_go),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (chaos_data),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Sequencer next state: warm-up countdown, capture counting, abort handling
    always_comb begin
        w_state_next    = r_state;
        w_warm_cnt_next = r_warm_cnt;
        w_cap_cnt_next  = r_cap_cnt;
        case (r_state)
            StIdle, StDone: begin
                if (w_go) begin
                    w_cap_cnt_next  = '0;
                    w_warm_cnt_next = r_warmup;
                    w_state_next    = (r_warmup == '0) ? StCollect : StWarm;
                end
            end
            StWarm: begin
                if (w_abort) begin
                    w_state_next = StIdle;
                end else if (r_warm_cnt <= WARM_W'(1)) begin
                    w_state_next = StCollect;
                end else begin
                    w_warm_cnt_next = r_warm_cnt - WARM_W'(1);
                end
            end
            StCollect: begin
                if (w_abort) begin
                    w_state_next = StIdle;
                end else if (w_push) begin
                    w_cap_cnt_next = w_cap_inc;
                    if (w_last) w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Sequencer state; chaos_en follows the busy-ness of the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_warm_cnt   <= '0;
            r_cap_cnt    <= '0;
            r_keylen_lat <= CNT_W'(DEPTH);
            r_chaos_en   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_warm_cnt <= w_warm_cnt_next;
            r_cap_cnt  <= w_cap_cnt_next;
            r_chaos_en <= (w_state_next == StWarm) || (w_state_next == StCollect);
            if (w_go) r_keylen_lat <= r_keylen;
        end
    end

    // Software-visible configuration and sticky status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_warmup    <= '0;
            r_keylen    <= CNT_W'(DEPTH);
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr && (address == ADDR_CTRL)) r_irq_en <= writedata[CTRL_IRQ_EN];
            if (w_wr && (address == ADDR_WARMUP)) r_warmup <= writedata[WARM_W-1:0];
            if (w_wr && (address == ADDR_KEYLEN)) begin
                if ((writedata == 32'd0) || (writedata > 32'(DEPTH))) begin
                    r_keylen <= CNT_W'(DEPTH);
                end else begin
                    r_keylen <= writedata[CNT_W-1:0];
                end
            end
            // Set beats W1C clear
            if (w_go) begin
                r_done <= 1'b0;
            end else if (w_last) begin
                r_done <= 1'b1;
            end else if (w_status_wr && writedata[STAT_DONE]) begin
                r_done <= 1'b0;
            end
            if (w_go) begin
                r_underflow <= 1'b0;
            end else if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end else if (w_status_wr && writedata[STAT_UNDERFLOW]) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Zero-latency read mux
    always_comb begin
        readdata = '0;
        if (w_rd) begin
            case (address)
                ADDR_CTRL: readdata[CTRL_IRQ_EN] = r_irq_en;
                ADDR_STATUS: begin
                    readdata[STAT_BUSY]                       = w_busy;
                    readdata[STAT_DONE]                       = r_done;
                    readdata[STAT_UNDERFLOW]                  = r_underflow;
                    readdata[STAT_COUNT_LSB+7:STAT_COUNT_LSB] = 8'(w_count);
                end
                ADDR_WARMUP: readdata[WARM_W-1:0] = r_warmup;
                ADDR_KEYLEN: readdata[CNT_W-1:0]  = r_keylen;
                ADDR_KEYDATA: begin
                    if (!w_empty) readdata[DATA_W-1:0] = w_head;
                end
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_chaos_key_ctrl.sv
// Directed self-checking bench for chaos_key_ctrl.
module tb_chaos_key_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        chaos_en;
    logic        chaos_valid;
    logic [31:0] chaos_data;

    int n_checks = 0;
    int n_errors = 0;

    chaos_key_ctrl #(
        .DATA_W (32),
        .DEPTH  (8),
        .WARM_W (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .read_n      (read_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq),
        .chaos_en    (chaos_en),
        .chaos_valid (chaos_valid),
        .chaos_data  (chaos_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic pulse_word(input logic [31:0] d);
        @(negedge clk);
        chaos_valid = 1'b1;
        chaos_data  = d;
        @(negedge clk);
        chaos_valid = 1'b0;
    endtask

    logic [31:0] rd;
    int          n_en;

    initial begin
        reset_n     = 1'b0;
        address     = '0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        read_n      = 1'b1;
        writedata   = '0;
        chaos_valid = 1'b0;
        chaos_data  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_chaos_en", {31'b0, chaos_en}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        bus_read(3'd0, rd);  check("rst_ctrl", rd, 32'd0);
        bus_read(3'd1, rd);  check("rst_status", rd, 32'd0);
        bus_read(3'd2, rd);  check("rst_warmup", rd, 32'd0);
        bus_read(3'd3, rd);  check("rst_keylen", rd, 32'd8);
        bus_read(3'd5, rd);  check("rd_addr5", rd, 32'd0);

        // KEYLEN clamping
        bus_write(3'd3, 32'd9);  bus_read(3'd3, rd); check("keylen_9", rd, 32'd8);
        bus_write(3'd3, 32'd3);  bus_read(3'd3, rd); check("keylen_3", rd, 32'd3);

        // Session 1: WARMUP=4, KEYLEN=3, continuous valid stream
        bus_write(3'd2, 32'd4);
        @(negedge clk);
        chipselect  = 1'b1;
        write_n     = 1'b0;
        address     = 3'd0;
        writedata   = 32'h5;
        chaos_valid = 1'b1;
        chaos_data  = 32'hA0;
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chipselect = 1'b0;
            write_n    = 1'b1;
            if (chaos_en) n_en++;
            chaos_data = 32'hA1 + i;
        end
        chaos_valid = 1'b0;
        check("s1_en_cycles", n_en, 32'd7);
        check("s1_irq", {31'b0, irq}, 32'd1);
        check("s1_chaos_en", {31'b0, chaos_en}, 32'd0);
        bus_read(3'd1, rd);  check("s1_status", rd, 32'h0302);
        bus_read(3'd4, rd);  check("s1_key0", rd, 32'hA5);
        bus_read(3'd4, rd);  check("s1_key1", rd, 32'hA6);
        bus_read(3'd4, rd);  check("s1_key2", rd, 32'hA7);
        bus_read(3'd4, rd);  check("s1_key_empty", rd, 32'd0);
        bus_read(3'd1, rd);  check("s1_status_uf", rd, 32'h0006);
        bus_write(3'd1, 32'h6);
        check("s1_irq_clr", {31'b0, irq}, 32'd0);
        bus_read(3'd1, rd);  check("s1_status_clr", rd, 32'h0000);

        // Session 2: WARMUP=0, KEYLEN=0 -> DEPTH, sparse pulses
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'd0);
        bus_read(3'd3, rd);  check("s2_keylen", rd, 32'd8);
        bus_write(3'd0, 32'h5);
        check("s2_chaos_en", {31'b0, chaos_en}, 32'd1);
        bus_read(3'd1, rd);  check("s2_collect", rd, 32'h0001);
        for (int i = 0; i < 8; i++) pulse_word(32'h10 + i);
        bus_read(3'd1, rd);  check("s2_status", rd, 32'h0802);
        check("s2_chaos_en_off", {31'b0, chaos_en}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'd4, rd);
            check($sformatf("s2_key%0d", i), rd, 32'h10 + i);
        end

        // Session 3: abort after 2 words, then restart flushes
        bus_write(3'd0, 32'h5);
        pulse_word(32'h31);
        pulse_word(32'h32);
        bus_write(3'd0, 32'h6);
        check("s3_abort_en", {31'b0, chaos_en}, 32'd0);
        bus_read(3'd1, rd);  check("s3_abort_status", rd, 32'h0200);
        bus_write(3'd0, 32'h5);
        bus_read(3'd1, rd);  check("s3_restart", rd, 32'h0001);

        // Simultaneous pop and push in COLLECT; start while busy ignored
        pulse_word(32'h51);
        @(negedge clk);
        chipselect  = 1'b1;
        read_n      = 1'b0;
        address     = 3'd4;
        chaos_valid = 1'b1;
        chaos_data  = 32'h52;
        #1 check("s4_pop_head", readdata, 32'h51);
        @(negedge clk);
        chipselect  = 1'b0;
        read_n      = 1'b1;
        chaos_valid = 1'b0;
        bus_read(3'd1, rd);  check("s4_count", rd, 32'h0101);
        bus_write(3'd0, 32'h5);
        bus_read(3'd1, rd);  check("s4_start_busy", rd, 32'h0101);
        bus_read(3'd4, rd);  check("s4_order", rd, 32'h52);
        bus_write(3'd0, 32'h6);

        // Session 5: short capture with irq, then reset during WARM
        bus_write(3'd3, 32'd1);
        bus_write(3'd0, 32'h5);
        pulse_word(32'h61);
        check("s5_irq", {31'b0, irq}, 32'd1);
        bus_read(3'd1, rd);  check("s5_status", rd, 32'h0102);
        bus_write(3'd2, 32'd20);
        bus_write(3'd0, 32'h5);
        check("s5_warm_en", {31'b0, chaos_en}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("s5_rst_en", {31'b0, chaos_en}, 32'd0);
        check("s5_rst_irq", {31'b0, irq}, 32'd0);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd1;
        #1 check("s5_rst_status", readdata, 32'd0);
        chipselect = 1'b0;
        read_n     = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd3, rd);  check("s5_keylen", rd, 32'd8);
        bus_read(3'd2, rd);  check("s5_warmup", rd, 32'd0);
        bus_read(3'd0, rd);  check("s5_ctrl", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
